// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares the genrom read port between instruction fetch and data load.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise fetch has fixed priority.
module mem_arbiter #(
  parameter int MEM_DEPTH = 6,
  parameter int MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          f_req,
  input  logic [MEM_DEPTH:0]            f_addr,
  input  logic [MEM_EXTRA-1:0]          f_extra,
  input  logic [MEM_DEPTH:0]            f_lower,
  input  logic [MEM_DEPTH:0]            f_upper,
  output logic                          f_gnt,
  output logic                          f_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]   f_data,
  output logic                          f_error,

  input  logic                          d_req,
  input  logic [MEM_DEPTH:0]            d_addr,
  input  logic [MEM_EXTRA-1:0]          d_extra,
  input  logic [MEM_DEPTH:0]            d_lower,
  input  logic [MEM_DEPTH:0]            d_upper,
  output logic                          d_gnt,
  output logic                          d_valid,
  output logic [(2**MEM_EXTRA)*8-1:0]   d_data,
  output logic                          d_error,

  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  output logic [MEM_DEPTH:0]            mem_lower_bound,
  output logic [MEM_DEPTH:0]            mem_upper_bound,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   win;

  // 0 = fetch wins, 1 = data wins; only meaningful when a request is pending
  always_comb begin
    win = 1'b0;
    if (f_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = ~last;
`else
      win = 1'b0;
`endif
    end else begin
      win = d_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      owner           <= 1'b0;
      last            <= 1'b1;
      mem_addr        <= '0;
      mem_extra       <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '1;
      f_gnt           <= 1'b0;
      d_gnt           <= 1'b0;
      f_valid         <= 1'b0;
      d_valid         <= 1'b0;
    end else begin
      f_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (f_req || d_req) begin
            owner <= win;
            last  <= win;
            f_gnt <= ~win;
            d_gnt <= win;
            if (win) begin
              mem_addr        <= d_addr;
              mem_extra       <= d_extra;
              mem_lower_bound <= d_lower;
              mem_upper_bound <= d_upper;
            end else begin
              mem_addr        <= f_addr;
              mem_extra       <= f_extra;
              mem_lower_bound <= f_lower;
              mem_upper_bound <= f_upper;
            end
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // ROM captures mem_* at this edge, so its registered response lines up with RESP
          f_valid <= ~owner;
          d_valid <= owner;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign f_data  = f_valid ? mem_data : '0;
  assign d_data  = d_valid ? mem_data : '0;
  assign f_error = f_valid & mem_error;
  assign d_error = d_valid & mem_error;

endmodule
